// File: rtl/acseq_pkg.sv
// -----------------------------------------------------------------------------
// acseq_pkg
// Shared types and constants for the ac_sequencer block.
//   op_e    : operation code captured with start (3 bits)
//   state_e : sequencer FSM states, also exported on the debug state output
//   ACSEQ_W / ACSEQ_MAX / ACSEQ_MIN : default datapath width and its signed
//             limits (modules derive their own limits from WIDTH)
// -----------------------------------------------------------------------------
package acseq_pkg;

   localparam int ACSEQ_W = 8;
   localparam logic [ACSEQ_W-1:0] ACSEQ_MAX = {1'b0, {(ACSEQ_W-1){1'b1}}};
   localparam logic [ACSEQ_W-1:0] ACSEQ_MIN = {1'b1, {(ACSEQ_W-1){1'b0}}};

   typedef enum logic [2:0] {
      OP_LOAD = 3'd0,
      OP_ADD  = 3'd1,
      OP_SUB  = 3'd2,
      OP_AND  = 3'd3,
      OP_OR   = 3'd4,
      OP_XOR  = 3'd5,
      OP_NEG  = 3'd6,
      OP_MUL  = 3'd7
   } op_e;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_EXEC  = 3'd1,
      S_MUL   = 3'd2,
      S_WRITE = 3'd3,
      S_DONE  = 3'd4
   } state_e;

endpackage

// File: rtl/acseq_alu.sv
// -----------------------------------------------------------------------------
// acseq_alu
// Combinational result/overflow stage. Computes the single-step ops directly
// from A and B; for MUL it takes the finished 2*WIDTH signed product and only
// performs the range check and narrowing.
// Ports:
//   i_op   : operation
//   i_a    : signed A (captured AC value)
//   i_b    : signed B (captured operand)
//   i_prod : full signed product, used only for OP_MUL
//   o_res  : WIDTH-bit result (wrapped or clamped)
//   o_v    : signed overflow of the true result
// Build option: AC_SATURATE_EN defined -> overflowing ADD/SUB/NEG/MUL clamp to
// MAX/MIN by the sign of the true result; undefined -> results wrap.
// -----------------------------------------------------------------------------
module acseq_alu
   import acseq_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  op_e              i_op,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic [2*WIDTH-1:0] i_prod,
   output logic [WIDTH-1:0] o_res,
   output logic             o_v
);

`ifdef AC_SATURATE_EN
   localparam bit SAT_EN = 1'b1;
`else
   localparam bit SAT_EN = 1'b0;
`endif

   localparam logic [WIDTH-1:0] MAX_V = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};

   // One extra bit of headroom: the top bit is the true sign, and a
   // disagreement between the top two bits means the result left the range.
   logic [WIDTH:0]   w_a_x;
   logic [WIDTH:0]   w_b_x;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_diff;
   logic [WIDTH:0]   w_neg;
   logic [WIDTH-1:0] w_wrap;
   logic             w_ovf;
   logic             w_sign;
   logic [WIDTH:0]   w_prod_hi;

   always_comb begin
      w_a_x     = {i_a[WIDTH-1], i_a};
      w_b_x     = {i_b[WIDTH-1], i_b};
      w_sum     = w_a_x + w_b_x;
      w_diff    = w_a_x - w_b_x;
      w_neg     = '0 - w_a_x;
      w_prod_hi = i_prod[2*WIDTH-1:WIDTH-1];
      w_wrap    = '0;
      w_ovf     = 1'b0;
      w_sign    = 1'b0;
      case (i_op)
         OP_LOAD: w_wrap = i_b;
         OP_ADD: begin
            w_wrap = w_sum[WIDTH-1:0];
            w_ovf  = w_sum[WIDTH] ^ w_sum[WIDTH-1];
            w_sign = w_sum[WIDTH];
         end
         OP_SUB: begin
            w_wrap = w_diff[WIDTH-1:0];
            w_ovf  = w_diff[WIDTH] ^ w_diff[WIDTH-1];
            w_sign = w_diff[WIDTH];
         end
         OP_AND: w_wrap = i_a & i_b;
         OP_OR:  w_wrap = i_a | i_b;
         OP_XOR: w_wrap = i_a ^ i_b;
         OP_NEG: begin
            w_wrap = w_neg[WIDTH-1:0];
            w_ovf  = w_neg[WIDTH] ^ w_neg[WIDTH-1];
            w_sign = w_neg[WIDTH];
         end
         OP_MUL: begin
            // The product fits iff its upper half plus the result MSB are a
            // pure sign extension.
            w_wrap = i_prod[WIDTH-1:0];
            w_ovf  = !((&w_prod_hi) || (~|w_prod_hi));
            w_sign = i_prod[2*WIDTH-1];
         end
         default: w_wrap = '0;
      endcase
      o_v   = w_ovf;
      o_res = (SAT_EN && w_ovf) ? (w_sign ? MIN_V : MAX_V) : w_wrap;
   end

endmodule

// File: rtl/ac_sequencer.sv
// -----------------------------------------------------------------------------
// ac_sequencer
// Control/ALU stage in front of the ac accumulator. Captures one operation per
// accepted start, computes op(A, B) (MUL by an iterative signed shift-add, one
// multiplier bit per cycle) and writes the result back through a one-cycle
// LOAD_AC strobe.
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   start, op, operand : request, op code and signed B (captured together)
//   AC_in              : current ac value, signed A (captured with start)
//   Z                  : registered result for ac.Z, stable through WRITE
//   LOAD_AC            : high for exactly the WRITE cycle
//   busy, done         : busy outside IDLE; done pulses one cycle after WRITE
//   flag_n/z/v         : result MSB, result zero, signed overflow
//   o_dbg_state        : current FSM state
// Build option: AC_SATURATE_EN (see acseq_alu) selects clamping over wrapping.
//
// Handshake: start is sampled only while busy is low (IDLE); a sampled start
// is the accept and captures op/operand/AC_in. While busy is high start is
// ignored and never queued. done marks the cycle in which AC_in already holds
// the new value; the next start can be accepted in the following IDLE cycle.
// -----------------------------------------------------------------------------
module ac_sequencer
   import acseq_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  op_e              op,
   input  logic [WIDTH-1:0] operand,
   input  logic [WIDTH-1:0] AC_in,
   output logic [WIDTH-1:0] Z,
   output logic             LOAD_AC,
   output logic             busy,
   output logic             done,
   output logic             flag_n,
   output logic             flag_z,
   output logic             flag_v,
   output state_e           o_dbg_state
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   state_e             r_state;
   state_e             w_state_nxt;
   op_e                r_op;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [2*WIDTH-1:0] r_prod;
   logic [2*WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0]   r_mplier;
   logic [CW-1:0]      r_cnt;
   logic [WIDTH-1:0]   r_z;
   logic               r_n;
   logic               r_zf;
   logic               r_v;

   logic               w_capture;
   logic               w_mul_init;
   logic               w_mul_step;
   logic               w_load_z;
   logic               w_last;
   logic [2*WIDTH-1:0] w_addend;
   logic [2*WIDTH-1:0] w_prod_nxt;
   logic [WIDTH-1:0]   w_res;
   logic               w_v;

   // Signed shift-add: multiplier bits below the MSB add the shifted
   // multiplicand; the MSB carries weight -2^(WIDTH-1), so it subtracts.
   always_comb begin
      w_last     = (r_cnt == LAST_CNT);
      w_addend   = r_mplier[0] ? (w_last ? ('0 - r_mcand) : r_mcand) : '0;
      w_prod_nxt = r_prod + w_addend;
   end

   acseq_alu #(.WIDTH(WIDTH)) u_alu (
      .i_op   (r_op),
      .i_a    (r_a),
      .i_b    (r_b),
      .i_prod (w_prod_nxt),
      .o_res  (w_res),
      .o_v    (w_v)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      LOAD_AC     = 1'b0;
      busy        = 1'b1;
      done        = 1'b0;
      w_capture   = 1'b0;
      w_mul_init  = 1'b0;
      w_mul_step  = 1'b0;
      w_load_z    = 1'b0;
      case (r_state)
         S_IDLE: begin
            busy = 1'b0;
            if (start) begin
               w_capture   = 1'b1;
               w_state_nxt = S_EXEC;
            end
         end
         S_EXEC: begin
            if (r_op == OP_MUL) begin
               w_mul_init  = 1'b1;
               w_state_nxt = S_MUL;
            end else begin
               w_load_z    = 1'b1;
               w_state_nxt = S_WRITE;
            end
         end
         S_MUL: begin
            w_mul_step = 1'b1;
            if (w_last) begin
               w_load_z    = 1'b1;
               w_state_nxt = S_WRITE;
            end
         end
         S_WRITE: begin
            LOAD_AC     = 1'b1;
            w_state_nxt = S_DONE;
         end
         S_DONE: begin
            done        = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: begin
            busy        = 1'b0;
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_op     <= OP_LOAD;
         r_a      <= '0;
         r_b      <= '0;
         r_prod   <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_cnt    <= '0;
         r_z      <= '0;
         r_n      <= 1'b0;
         r_zf     <= 1'b0;
         r_v      <= 1'b0;
      end else begin
         if (w_capture) begin
            r_op <= op;
            r_a  <= AC_in;
            r_b  <= operand;
         end
         if (w_mul_init) begin
            r_prod   <= '0;
            r_mcand  <= {{WIDTH{r_a[WIDTH-1]}}, r_a};
            r_mplier <= r_b;
            r_cnt    <= '0;
         end
         if (w_mul_step) begin
            r_prod   <= w_prod_nxt;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CW'(1);
         end
         // Flags follow the final (possibly clamped) result.
         if (w_load_z) begin
            r_z  <= w_res;
            r_n  <= w_res[WIDTH-1];
            r_zf <= (w_res == '0);
            r_v  <= w_v;
         end
      end
   end

   assign Z           = r_z;
   assign flag_n      = r_n;
   assign flag_z      = r_zf;
   assign flag_v      = r_v;
   assign o_dbg_state = r_state;

endmodule
